// File: rtl/multicycle_control_pkg.sv
// Shared types and mux-select encodings for the multicycle RISC control path.
package multicycle_control_pkg;

  // Writeback mux select
  localparam logic [1:0] WB_ALU      = 2'd0;
  localparam logic [1:0] WB_DATA_MEM = 2'd1;
  localparam logic [1:0] WB_PC       = 2'd2;
  localparam logic [1:0] WB_IMM      = 2'd3;

  // Next-PC mux select
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  typedef enum logic [6:0] {
    OpLoad    = 7'h03,
    OpMiscMem = 7'h0f,
    OpImm     = 7'h13,
    OpAuipc   = 7'h17,
    OpStore   = 7'h23,
    OpOp      = 7'h33,
    OpLui     = 7'h37,
    OpBranch  = 7'h63,
    OpJalr    = 7'h67,
    OpJal     = 7'h6f,
    OpSystem  = 7'h73
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWb,
    StHalt
  } ctrl_state_e;

  typedef struct packed {
    logic [1:0] wb;
    logic       alu1;
    logic       alu2;
    logic [1:0] pc;
    logic       rf_wr;
    logic       mem;
    logic       store;
    logic       legal;
  } ctrl_sel_t;

endpackage

// File: rtl/multicycle_control_decoder.sv
// Combinational opcode decode into the control-select bundle.
module ctrl_decoder
  import multicycle_control_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_sel_t  sel
);

  always_comb begin
    sel       = '0;
    sel.wb    = WB_ALU;
    sel.pc    = PC_PLUS4;
    sel.legal = 1'b1;
    case (opcode)
      OpLui: begin
        sel.wb    = WB_IMM;
        sel.rf_wr = 1'b1;
      end
      OpAuipc: begin
        sel.alu1  = 1'b1;
        sel.alu2  = 1'b1;
        sel.rf_wr = 1'b1;
      end
      OpJal: begin
        sel.wb    = WB_PC;
        sel.pc    = PC_IMM;
        sel.rf_wr = 1'b1;
      end
      OpJalr: begin
        sel.alu2  = 1'b1;
        sel.wb    = WB_PC;
        sel.pc    = PC_ALU;
        sel.rf_wr = 1'b1;
      end
      // Branch target is resolved in EXECUTE from br_taken.
      OpBranch: ;
      OpLoad: begin
        sel.alu2  = 1'b1;
        sel.wb    = WB_DATA_MEM;
        sel.rf_wr = 1'b1;
        sel.mem   = 1'b1;
      end
      OpStore: begin
        sel.alu2  = 1'b1;
        sel.mem   = 1'b1;
        sel.store = 1'b1;
      end
      OpImm: begin
        sel.alu2  = 1'b1;
        sel.rf_wr = 1'b1;
      end
      OpOp: sel.rf_wr = 1'b1;
      OpMiscMem, OpSystem: ;
      default: sel.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle FETCH/DECODE/EXECUTE/MEM/WB sequencer with memory timeout.
// Define CTRL_ILLEGAL_TRAP_EN to halt on unknown opcodes (adds illegal_instr).
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic        br_taken,
  output logic [31:0] instr,
  output logic [1:0]  WBSel,
  output logic        ALUReg1PCSel,
  output logic        ALUReg2ImmSel,
  output logic [1:0]  PCSel,
  output logic        pc_we,
  output logic        rf_we,
  output logic        instr_retired,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic        illegal_instr,
`endif
  output logic        bus_error
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  ctrl_state_e     state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  ctrl_sel_t       sel_q, sel_d, dec_sel;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            bus_error_q, bus_error_d;
  logic            is_branch;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic            illegal_q, illegal_d;
`endif

  ctrl_decoder u_decoder (
    .opcode (instr_q[6:0]),
    .sel    (dec_sel)
  );

  assign is_branch = (instr_q[6:0] == OpBranch);

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    sel_d         = sel_q;
    wait_cnt_d    = wait_cnt_q;
    bus_error_d   = bus_error_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_d     = illegal_q;
`endif
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    pc_we         = 1'b0;
    rf_we         = 1'b0;
    instr_retired = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d    = StFetch;
        wait_cnt_d = '0;
      end
      StFetch: begin
        imem_req = 1'b1;
        // A ready arriving on the limit cycle still completes the fetch.
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = StDecode;
        end else if (wait_cnt_q == CntLast) begin
          state_d     = StHalt;
          bus_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      StDecode: begin
        sel_d   = dec_sel;
        state_d = StExecute;
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (!dec_sel.legal) begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end
`endif
      end
      StExecute: begin
        if (is_branch) sel_d.pc = br_taken ? PC_IMM : PC_PLUS4;
        if (sel_q.mem) begin
          state_d    = StMem;
          wait_cnt_d = '0;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = sel_q.store;
        if (dmem_ready) begin
          state_d = StWb;
        end else if (wait_cnt_q == CntLast) begin
          state_d     = StHalt;
          bus_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      StWb: begin
        pc_we         = 1'b1;
        instr_retired = 1'b1;
        rf_we         = sel_q.rf_wr && sel_q.legal && (instr_q[11:7] != 5'd0);
        state_d       = StFetch;
        wait_cnt_d    = '0;
      end
      StHalt: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      instr_q     <= '0;
      sel_q       <= '0;
      wait_cnt_q  <= '0;
      bus_error_q <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      sel_q       <= sel_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_error_q <= bus_error_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q   <= illegal_d;
`endif
    end
  end

  assign instr         = instr_q;
  assign WBSel         = sel_q.wb;
  assign ALUReg1PCSel  = sel_q.alu1;
  assign ALUReg2ImmSel = sel_q.alu2;
  assign PCSel         = sel_q.pc;
  assign bus_error     = bus_error_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_instr = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control against a per-instruction reference model.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  localparam int TO = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        dmem_req, dmem_we, dmem_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] instr;
  logic [1:0]  WBSel, PCSel;
  logic        ALUReg1PCSel, ALUReg2ImmSel;
  logic        pc_we, rf_we, instr_retired, bus_error;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TrapBuild = 1'b1;
  logic        illegal_instr;
`else
  localparam bit TrapBuild = 1'b0;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_control #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_ready    (dmem_ready),
    .br_taken      (br_taken),
    .instr         (instr),
    .WBSel         (WBSel),
    .ALUReg1PCSel  (ALUReg1PCSel),
    .ALUReg2ImmSel (ALUReg2ImmSel),
    .PCSel         (PCSel),
    .pc_we         (pc_we),
    .rf_we         (rf_we),
    .instr_retired (instr_retired),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal_instr (illegal_instr),
`endif
    .bus_error     (bus_error)
  );

  typedef struct packed {
    logic [1:0] wb;
    logic       a1;
    logic       a2;
    logic [1:0] pc;
    logic       wr_class;
    logic       wr;
    logic       mem;
    logic       st;
    logic       legal;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Architectural expectation for one instruction, straight from the opcode table.
  function automatic exp_t model(input logic [31:0] ins, input bit bt);
    exp_t e;
    e       = '0;
    e.wb    = WB_ALU;
    e.pc    = PC_PLUS4;
    e.legal = 1'b1;
    case (ins[6:0])
      7'h37: begin e.wb = WB_IMM; e.wr_class = 1'b1; end
      7'h17: begin e.a1 = 1'b1; e.a2 = 1'b1; e.wr_class = 1'b1; end
      7'h6f: begin e.wb = WB_PC; e.pc = PC_IMM; e.wr_class = 1'b1; end
      7'h67: begin e.a2 = 1'b1; e.wb = WB_PC; e.pc = PC_ALU; e.wr_class = 1'b1; end
      7'h63: e.pc = bt ? PC_IMM : PC_PLUS4;
      7'h03: begin e.a2 = 1'b1; e.wb = WB_DATA_MEM; e.wr_class = 1'b1; e.mem = 1'b1; end
      7'h23: begin e.a2 = 1'b1; e.mem = 1'b1; e.st = 1'b1; end
      7'h13: begin e.a2 = 1'b1; e.wr_class = 1'b1; end
      7'h33: e.wr_class = 1'b1;
      7'h0f, 7'h73: ;
      default: e.legal = 1'b0;
    endcase
    e.wr = e.wr_class && (ins[11:7] != 5'd0);
    return e;
  endfunction

  task automatic do_reset();
    rst        = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(negedge clk);
    check("rst_imem_req", imem_req, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_dmem_we", dmem_we, 0);
    check("rst_strobes", {pc_we, rf_we, instr_retired}, 0);
    check("rst_bus_error", bus_error, 0);
    check("rst_instr", instr, 0);
    check("rst_sel", {WBSel, ALUReg1PCSel, ALUReg2ImmSel, PCSel}, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("rst_illegal", illegal_instr, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    check("idle_req", imem_req, 0);
    @(negedge clk);
    check("fetch_req", imem_req, 1);
  endtask

  // Runs one instruction from a FETCH cycle; waits >= TO model a dead memory.
  task automatic do_instr(input logic [31:0] ins, input int fwait, input int mwait, input bit bt);
    exp_t e;
    bit f_to, m_to, trap, halted, done;
    int exp_f, exp_m, exp_cyc;
    int cyc, fc, mc, npc, nrf, nret, we_bad, quiet;
    logic rf_at, pc_at, a1_at, a2_at;
    logic [1:0] wb_at, pcs_at;
    logic [31:0] r;
    e       = model(ins, bt);
    f_to    = fwait >= TO;
    trap    = TrapBuild && !e.legal && !f_to;
    m_to    = !f_to && !trap && e.mem && (mwait >= TO);
    halted  = f_to || m_to || trap;
    exp_f   = f_to ? TO : fwait + 1;
    exp_m   = (f_to || trap || !e.mem) ? 0 : (m_to ? TO : mwait + 1);
    exp_cyc = f_to ? exp_f + 1 : (trap ? exp_f + 2 : exp_f + 3 + exp_m);
    cyc = 0; fc = 0; mc = 0; npc = 0; nrf = 0; nret = 0; we_bad = 0; done = 1'b0;
    rf_at = 1'b0; pc_at = 1'b0; a1_at = 1'b0; a2_at = 1'b0; wb_at = '0; pcs_at = '0;
    br_taken = bt;
    while (!done && cyc < 1000) begin
      cyc++;
      r = $urandom;
      if (imem_req) begin
        fc++;
        imem_ready = (fc == fwait + 1);
      end else begin
        imem_ready = r[0];
      end
      imem_rdata = (imem_req && imem_ready) ? ins : $urandom;
      if (dmem_req) begin
        mc++;
        dmem_ready = (mc == mwait + 1);
        if (dmem_we !== e.st) we_bad++;
      end else begin
        dmem_ready = r[1];
      end
      npc  += int'(pc_we);
      nrf  += int'(rf_we);
      nret += int'(instr_retired);
      if (instr_retired) begin
        done   = 1'b1;
        rf_at  = rf_we;
        pc_at  = pc_we;
        wb_at  = WBSel;
        pcs_at = PCSel;
        a1_at  = ALUReg1PCSel;
        a2_at  = ALUReg2ImmSel;
      end
      if (bus_error) done = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (illegal_instr) done = 1'b1;
`endif
      @(negedge clk);
    end
    check("latency", cyc, exp_cyc);
    check("imem_req_cycles", fc, exp_f);
    check("dmem_req_cycles", mc, exp_m);
    check("dmem_we", we_bad, 0);
    check("retired_count", nret, halted ? 0 : 1);
    check("pc_we_count", npc, halted ? 0 : 1);
    check("rf_we_count", nrf, (!halted && e.wr) ? 1 : 0);
    check("bus_error", bus_error, f_to || m_to);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("illegal_instr", illegal_instr, trap);
`endif
    if (!halted) begin
      check("rf_we_at_wb", rf_at, e.wr);
      check("pc_we_at_wb", pc_at, 1);
      check("instr_reg", instr, ins);
      check("alu1_sel", a1_at, e.a1);
      check("alu2_sel", a2_at, e.a2);
      check("pc_sel", pcs_at, e.pc);
      if (e.wr_class) check("wb_sel", wb_at, e.wb);
    end else begin
      quiet = 0;
      for (int i = 0; i < 8; i++) begin
        r          = $urandom;
        imem_ready = r[0];
        dmem_ready = r[1];
        quiet += int'(imem_req | dmem_req | pc_we | rf_we | instr_retired);
        @(negedge clk);
      end
      check("halt_quiet", quiet, 0);
      check("halt_bus_error_sticky", bus_error, f_to || m_to);
      do_reset();
    end
  endtask

  // Abandons a load while its data request is pending.
  task automatic abort_test();
    int n;
    n          = 0;
    imem_rdata = 32'h0000a103;
    dmem_ready = 1'b0;
    while (!dmem_req && n < 20) begin
      imem_ready = imem_req;
      n++;
      @(negedge clk);
    end
    check("abort_reach_mem", dmem_req, 1);
    do_reset();
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] ins;
    logic [6:0]  ops [13];
    ops = '{7'h03, 7'h0f, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6f, 7'h73,
            7'h7f, 7'h0b};

    do_reset();
    do_instr(32'h00500093, 0, 0, 1'b0);   // addi x1,x0,5
    do_instr(32'h0000a103, 0, 3, 1'b0);   // lw x2,0(x1)
    do_instr(32'h0020a223, 1, 0, 1'b0);   // sw x2,4(x1)
    do_instr(32'h00000063, 0, 0, 1'b1);   // beq taken
    do_instr(32'h00000063, 2, 0, 1'b0);   // beq not taken
    do_instr(32'h0000006f, 0, 0, 1'b0);   // jal x0
    do_instr(32'h000002b7, 0, 0, 1'b0);   // lui x5
    do_instr(32'h00000317, 0, 0, 1'b0);   // auipc x6
    do_instr(32'h000080e7, 0, 0, 1'b0);   // jalr x1
    do_instr(32'h002081b3, 0, 0, 1'b0);   // add x3
    do_instr(32'h0000007f, 0, 0, 1'b0);   // unknown opcode
    do_instr(32'h00500093, TO - 1, 0, 1'b0);
    do_instr(32'h0000a103, 0, TO - 1, 1'b0);
    do_instr(32'h00500093, TO, 0, 1'b0);
    do_instr(32'h0020a223, 0, TO, 1'b0);
    abort_test();

    for (int i = 0; i < 60; i++) begin
      r   = $urandom;
      ins = {r[31:7], ops[$urandom_range(0, 12)]};
      if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
      do_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
